muldiv: RTL

Iterative RV32M multiply/divide unit, parametrised in operand width, that sits beside the single-cycle `alu` in the execute stage. Accepts one operation through a valid/ready handshake, computes one result bit per cycle (shift-add multiply, restoring divide), then holds the result until the consumer takes it. Status encoding matches the ALU: {NEGATIVE, OVERFLOW, ZERO}. Corner cases (divide-by-zero, signed overflow) bypass the iteration.

---
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/response handshake bundle for the iterative
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] Ain;
    logic [XLEN-1:0] Bin;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic [2:0]      status;

    modport master (
        output in_valid, op, Ain, Bin, flush, out_ready,
        input  in_ready, out_valid, out, status
    );

    modport slave (
        input  in_valid, op, Ain, Bin, flush, out_ready,
        output in_ready, out_valid, out, status
    );
endinterface
`default_nettype wire

// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
// Module      : muldiv
// Description : Iterative RV32M multiply/divide, one result bit per cycle.
//               Divide datapath is present only when MULDIV_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int              c_CW   = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

    state_t            r_state, w_state_nx;
    logic [c_CW-1:0]   r_cnt;
    logic [1:0]        r_op;
    logic              r_sa, r_sb, r_ovf;
    logic [XLEN-1:0]   r_hi, r_lo, r_d, r_out;

    logic              w_accept, w_last, w_sa, w_sb;
    logic              w_fast, w_fast_ovf;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_fast_out, w_lo_ld, w_d_ld;
    logic [XLEN-1:0]   w_hi_nx, w_lo_nx, w_result, w_mul_res;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mprod, w_mprod_fix;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE) && !bus.flush;
    assign w_last   = (r_cnt == c_LAST);

    assign w_sa = bus.Ain[XLEN-1] && (bus.op == 3'b001 || bus.op == 3'b010 ||
                                      bus.op == 3'b100 || bus.op == 3'b110);
    assign w_sb = bus.Bin[XLEN-1] && (bus.op == 3'b001 || bus.op == 3'b100 ||
                                      bus.op == 3'b110);
    assign w_abs_a = w_sa ? -bus.Ain : bus.Ain;
    assign w_abs_b = w_sb ? -bus.Bin : bus.Bin;

    // Shift-add: r_lo holds the multiplier and absorbs product low bits as it shifts out
    assign w_sum       = {1'b0, r_hi} + {1'b0, r_d & {XLEN{r_lo[0]}}};
    assign w_mprod     = {w_sum, r_lo[XLEN-1:1]};
    assign w_mprod_fix = (r_sa ^ r_sb) ? -w_mprod : w_mprod;
    assign w_mul_res   = (r_op == 2'b00) ? w_mprod_fix[XLEN-1:0]
                                         : w_mprod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    logic            r_div;
    logic            w_dz, w_sovf;
    logic [XLEN:0]   w_shift, w_trial;
    logic [XLEN-1:0] w_dhi, w_dlo, w_quo, w_rem;

    // Restoring divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_d};
    assign w_dhi   = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_dlo   = {r_lo[XLEN-2:0], ~w_trial[XLEN]};
    assign w_quo   = (r_sa ^ r_sb) ? -w_dlo : w_dlo;
    assign w_rem   = r_sa ? -w_dhi : w_dhi;

    assign w_hi_nx  = r_div ? w_dhi : w_sum[XLEN:1];
    assign w_lo_nx  = r_div ? w_dlo : w_mprod[XLEN-1:0];
    assign w_result = r_div ? (r_op[1] ? w_rem : w_quo) : w_mul_res;
    assign w_lo_ld  = bus.op[2] ? w_abs_a : w_abs_b;
    assign w_d_ld   = bus.op[2] ? w_abs_b : w_abs_a;

    assign w_dz       = bus.op[2] && (bus.Bin == '0);
    assign w_sovf     = (bus.op == 3'b100 || bus.op == 3'b110) &&
                        (bus.Ain == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.Bin);
    assign w_fast     = w_dz || w_sovf;
    assign w_fast_ovf = w_sovf;
    assign w_fast_out = w_dz ? (bus.op[1] ? bus.Ain : '1)
                             : (bus.op[1] ? '0 : bus.Ain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_div <= 1'b0;
        else if (w_accept) r_div <= bus.op[2];
    end
`else
    // Divide ops are reported as unsupported: zero result with the overflow flag set
    assign w_hi_nx    = w_sum[XLEN:1];
    assign w_lo_nx    = w_mprod[XLEN-1:0];
    assign w_result   = w_mul_res;
    assign w_lo_ld    = w_abs_b;
    assign w_d_ld     = w_abs_a;
    assign w_fast     = bus.op[2];
    assign w_fast_ovf = 1'b1;
    assign w_fast_out = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nx = w_fast ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last) w_state_nx = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
        if (bus.flush) w_state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_op  <= 2'b00;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_d   <= '0;
            r_out <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= bus.op[1:0];
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_hi  <= '0;
            r_lo  <= w_lo_ld;
            r_d   <= w_d_ld;
            if (w_fast) begin
                r_out <= w_fast_out;
                r_ovf <= w_fast_ovf;
            end
        end else if (r_state == ST_CALC && !bus.flush) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + c_CW'(1);
            if (w_last) begin
                r_out <= w_result;
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out       = r_out;
    assign bus.status    = {r_out[XLEN-1], r_ovf, (r_out == '0)};
endmodule
`default_nettype wire
